// File: rtl/fifo_ctrl.sv
// fifo_ctrl: pointer/flag controller for a single-clock 2**ADDR_WIDTH-deep RAM.
// Turns push/pop requests into RAM write/read strobes and addresses, tracks
// occupancy, and flags rejected requests. valid_out lines up with the RAM's
// one-cycle registered read data.
// Build option: FIFO_ERR_STICKY_EN makes overflow/underflow sticky until reset;
// without it they pulse for one cycle per rejected request.
module fifo_ctrl #(
  parameter int unsigned ADDR_WIDTH = 3,
  parameter int unsigned AF_THRESH  = 6,
  parameter int unsigned AE_THRESH  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  output logic                  we,
  output logic                  re,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  valid_out,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int unsigned CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(2 ** ADDR_WIDTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  valid_q;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;
  logic                  full_w, empty_w;
  logic                  acc_push, acc_pop;
  logic                  ovf_ev, unf_ev;

  // Occupancy flags, request acceptance and next-state for pointers/count/errors.
  always_comb begin
    full_w   = (count_q == DEPTH_C);
    empty_w  = (count_q == '0);
    // A push while full is still accepted if a pop frees the slot the same cycle.
    acc_pop  = pop & ~empty_w;
    acc_push = push & (~full_w | pop);
    ovf_ev   = push & full_w & ~pop;
    unf_ev   = pop & empty_w;

    wr_ptr_d = acc_push ? wr_ptr_q + ADDR_WIDTH'(1) : wr_ptr_q;
    rd_ptr_d = acc_pop  ? rd_ptr_q + ADDR_WIDTH'(1) : rd_ptr_q;

    count_d = count_q;
    case ({acc_push, acc_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

`ifdef FIFO_ERR_STICKY_EN
    ovf_d = ovf_q | ovf_ev;
    unf_d = unf_q | unf_ev;
`else
    ovf_d = ovf_ev;
    unf_d = unf_ev;
`endif
  end

  // State registers; reset discards contents and clears all status at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= acc_pop;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  assign we           = acc_push;
  assign re           = acc_pop;
  assign wr_addr      = wr_ptr_q;
  assign rd_addr      = rd_ptr_q;
  assign full         = full_w;
  assign empty        = empty_w;
  assign almost_full  = (count_q >= AF_C);
  assign almost_empty = (count_q <= AE_C);
  assign count        = count_q;
  assign valid_out    = valid_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

endmodule

// File: tb/tb_fifo_ctrl.sv
// Directed bench for fifo_ctrl (default 8-deep build, thresholds 6/2).
module tb_fifo_ctrl;

`ifdef FIFO_ERR_STICKY_EN
  localparam logic STICKY = 1'b1;
`else
  localparam logic STICKY = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset, push, pop;
  logic       we, re, full, empty, almost_full, almost_empty;
  logic       valid_out, overflow, underflow;
  logic [2:0] wr_addr, rd_addr;
  logic [3:0] count;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  fifo_ctrl #(.ADDR_WIDTH(3), .AF_THRESH(6), .AE_THRESH(2)) dut (
    .clk(clk), .reset(reset), .push(push), .pop(pop),
    .we(we), .re(re), .wr_addr(wr_addr), .rd_addr(rd_addr),
    .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
    .count(count), .valid_out(valid_out), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
  endtask

  initial begin
    reset = 1'b0; push = 1'b0; pop = 1'b0;
    #3;
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_ae", almost_empty, 1);
    chk("rst_full", full, 0);
    chk("rst_af", almost_full, 0);
    chk("rst_valid", valid_out, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_unf", underflow, 0);
    chk("rst_wa", wr_addr, 0);
    chk("rst_ra", rd_addr, 0);
    tick();
    reset = 1'b1;
    tick();

    // 1) fill with 8 pushes
    for (int i = 0; i < 8; i++) begin
      push = 1'b1; pop = 1'b0; #1;
      chk("fill_we", we, 1);
      chk("fill_re", re, 0);
      chk("fill_wa", wr_addr, i);
      tick();
      chk("fill_cnt", count, i + 1);
      chk("fill_full", full, (i == 7));
      chk("fill_af", almost_full, (i + 1 >= 6));
      chk("fill_ae", almost_empty, (i + 1 <= 2));
      chk("fill_empty", empty, 0);
    end

    // 2) push while full, no pop
    push = 1'b1; pop = 1'b0; #1;
    chk("ovf_we", we, 0);
    tick();
    chk("ovf_cnt", count, 8);
    chk("ovf_wa", wr_addr, 0);
    chk("ovf_flag", overflow, 1);
    push = 1'b0;
    tick();
    chk("ovf_after", overflow, STICKY);

    // 3) drain with 8 pops, then one extra pop
    for (int i = 0; i < 8; i++) begin
      pop = 1'b1; #1;
      chk("drain_re", re, 1);
      chk("drain_we", we, 0);
      chk("drain_ra", rd_addr, i);
      tick();
      chk("drain_cnt", count, 7 - i);
      chk("drain_valid", valid_out, 1);
      chk("drain_empty", empty, (i == 7));
    end
    pop = 1'b1; #1;
    chk("unf_re", re, 0);
    tick();
    chk("unf_flag", underflow, 1);
    chk("unf_valid", valid_out, 0);
    chk("unf_cnt", count, 0);
    pop = 1'b0;
    tick();
    chk("unf_after", underflow, STICKY);

    // 5) push+pop while empty, then 12 paired cycles wrapping the pointers
    push = 1'b1; pop = 1'b1; #1;
    chk("ep_re", re, 0);
    chk("ep_we", we, 1);
    chk("ep_wa", wr_addr, 0);
    tick();
    chk("ep_cnt", count, 1);
    chk("ep_unf", underflow, 1);
    chk("ep_valid", valid_out, 0);
    for (int i = 0; i < 12; i++) begin
      #1;
      chk("pair_we", we, 1);
      chk("pair_re", re, 1);
      chk("pair_wa", wr_addr, (i + 1) % 8);
      chk("pair_ra", rd_addr, i % 8);
      tick();
      chk("pair_cnt", count, 1);
      chk("pair_valid", valid_out, 1);
    end
    chk("wrap_wa", wr_addr, 5);
    chk("wrap_ra", rd_addr, 4);
    chk("pair_unf", underflow, STICKY);
    push = 1'b0; pop = 1'b1;
    tick();
    chk("pre4_cnt", count, 0);
    chk("pre4_ra", rd_addr, 5);

    // 4) refill, then push+pop while full
    push = 1'b1; pop = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    chk("refill_cnt", count, 8);
    chk("refill_full", full, 1);
    push = 1'b1; pop = 1'b1; #1;
    chk("fpp_we", we, 1);
    chk("fpp_re", re, 1);
    chk("fpp_wa", wr_addr, 5);
    chk("fpp_ra", rd_addr, 5);
    tick();
    chk("fpp_cnt", count, 8);
    chk("fpp_full", full, 1);
    chk("fpp_valid", valid_out, 1);
    chk("fpp_ovf", overflow, STICKY);
    push = 1'b0; pop = 1'b0;
    tick();
    chk("fpp_valid_off", valid_out, 0);

    // 6) async reset mid-operation after 5 pushes and 2 pops
    do_reset();
    push = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    push = 1'b0; pop = 1'b1;
    for (int i = 0; i < 2; i++) tick();
    pop = 1'b0;
    chk("mid_cnt", count, 3);
    chk("mid_valid", valid_out, 1);
    reset = 1'b0; #1;
    chk("arst_cnt", count, 0);
    chk("arst_empty", empty, 1);
    chk("arst_valid", valid_out, 0);
    chk("arst_wa", wr_addr, 0);
    chk("arst_ra", rd_addr, 0);
    chk("arst_ovf", overflow, 0);
    chk("arst_unf", underflow, 0);
    tick();
    reset = 1'b1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
